// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder: FSM state encoding,
// digit width and the decimal correction constants.
package bcd_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
    return d > BCD_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_slice.sv
// Single-digit BCD adder: binary sum of two digits plus carry, corrected by +6
// whenever the raw sum exceeds 9. Out-of-range digits use the same rule.
module bcd_digit_slice
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  input  logic             c_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);

  logic [BCD_W:0] t;
  logic [BCD_W:0] t_corr;

  always_comb begin
    t      = {1'b0, a_i} + {1'b0, b_i} + {{BCD_W{1'b0}}, c_i};
    t_corr = t + (BCD_W + 1)'(BCD_CORR);
    if (t > (BCD_W + 1)'(BCD_MAX)) begin
      digit_o = t_corr[BCD_W-1:0];
      carry_o = 1'b1;
    end else begin
      digit_o = t[BCD_W-1:0];
      carry_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD adder that reuses one digit slice, processing one digit per
// clock from the least significant end, with a start/done handshake.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W     = BCD_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       a_sh_q;
  logic [W-1:0]       b_sh_q;
  logic [W-1:0]       sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               err_q;

  logic [BCD_W-1:0]   digit_d;
  logic               carry_d;
  logic               op_err;

  always_comb begin
    op_err = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      op_err = op_err | digit_invalid(a[BCD_W*i +: BCD_W])
                      | digit_invalid(b[BCD_W*i +: BCD_W]);
    end
  end

  bcd_digit_slice u_slice (
    .a_i     (a_sh_q[BCD_W-1:0]),
    .b_i     (b_sh_q[BCD_W-1:0]),
    .c_i     (carry_q),
    .digit_o (digit_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= ADD;
            idx_q   <= '0;
            a_sh_q  <= a;
            b_sh_q  <= b;
            sum_q   <= '0;
            carry_q <= cin;
            cout_q  <= 1'b0;
            err_q   <= op_err;
          end else if (state_q == DONE) begin
            state_q <= IDLE;
          end
        end
        ADD: begin
          // operands shift down so the slice always sees the current digit at [3:0]
          sum_q[BCD_W*idx_q +: BCD_W] <= digit_d;
          a_sh_q  <= a_sh_q >> BCD_W;
          b_sh_q  <= b_sh_q >> BCD_W;
          carry_q <= carry_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            cout_q  <= carry_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for the 4-digit serial BCD adder with hand-computed results.
module tb_bcd_serial_adder_ctrl;

  localparam int unsigned DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for done after the accepting edge; returns edges taken (11 = timeout).
  task automatic wait_done(output int unsigned n);
    n = 11;
    for (int unsigned i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv);
    int unsigned n;
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, "_latency"}, n, DIGITS);
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("op1", 16'h1234, 16'h5678, 1'b0);
    check("op1_sum",  32'(sum),  32'h6912);
    check("op1_cout", 32'(cout), 32'd0);
    check("op1_err",  32'(err),  32'd0);
    @(posedge clk); #1;
    check("op1_done_pulse", 32'(done), 32'd0);
    check("op1_hold_sum",   32'(sum),  32'h6912);

    do_op("op2", 16'h9999, 16'h0001, 1'b0);
    check("op2_sum",  32'(sum),  32'h0000);
    check("op2_cout", 32'(cout), 32'd1);

    do_op("op3", 16'h9999, 16'h9999, 1'b1);
    check("op3_sum",  32'(sum),  32'h9999);
    check("op3_cout", 32'(cout), 32'd1);

    // digit1 = A+0 -> 0 carry 1 into digit2
    do_op("op4", 16'h00A0, 16'h0000, 1'b0);
    check("op4_sum",  32'(sum),  32'h0100);
    check("op4_cout", 32'(cout), 32'd0);
    check("op4_err",  32'(err),  32'd1);
    @(posedge clk); #1;
    check("op4_hold_err", 32'(err), 32'd1);

    do_op("op5", 16'h0005, 16'h0004, 1'b0);
    check("op5_sum", 32'(sum), 32'h0009);
    check("op5_err", 32'(err), 32'd0);

    // start held through ADD with changing operands, then back-to-back accept in DONE
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("bb_busy0", 32'(busy), 32'd1);
    a = 16'h4444; b = 16'h4444;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bb_busy_add", 32'(busy), 32'd1);
    end
    a = 16'h0555; b = 16'h0444;
    @(posedge clk); #1;
    check("bb_done1", 32'(done), 32'd1);
    check("bb_sum1",  32'(sum),  32'h3333);
    @(posedge clk); #1;
    start = 1'b0;
    check("bb_busy2", 32'(busy), 32'd1);
    check("bb_nodone", 32'(done), 32'd0);
    check("bb_clr_sum", 32'(sum), 32'd0);
    wait_done(n);
    check("bb_latency2", n, DIGITS);
    check("bb_sum2",  32'(sum),  32'h0999);
    check("bb_cout2", 32'(cout), 32'd0);

    // reset in second ADD cycle discards the operation
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_partial", 32'(sum), 32'h0002);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_sum",  32'(sum),  32'd0);
    check("mid_cout", 32'(cout), 32'd0);
    check("mid_err",  32'(err),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    check("mid_no_done", n, 0);

    do_op("op6", 16'h0046, 16'h0055, 1'b1);
    check("op6_sum",  32'(sum),  32'h0102);
    check("op6_cout", 32'(cout), 32'd0);
    check("op6_err",  32'(err),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
